// File: rtl/wb_hr_write_buffer.sv
// wb_hr_write_buffer: posted-write buffer in front of the HyperRAM driver.
// Writes are acked on entry to a small FIFO and drained in order in the
// background. Reads wait until the FIFO is empty and the downstream port is
// idle, then pass straight through, which keeps read-after-write ordering.
// Optional status outputs (level/busy) are enabled with `WB_HR_WBUF_STATUS_EN.
module wb_hr_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  input  logic          wbm_ack_i,
  input  logic [31:0]   wbm_dat_i
`ifdef WB_HR_WBUF_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] wbuf_level_o,
  output logic                   wbuf_busy_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_e;

  logic [AW-1:0] adr_mem [DEPTH];
  logic [3:0]    sel_mem [DEPTH];
  logic [31:0]   dat_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0] count_q;
  state_e        state_q;
  logic          ack_q, abort_q;
  logic [31:0]   rdat_q;
  logic          cyc_q, we_q;
  logic [3:0]    sel_q;
  logic [AW-1:0] adr_q;
  logic [31:0]   wdat_q;

  logic req, push, pop, rd_go;

  // A held strobe is masked while our own ack is up so it is taken only once.
  assign req    = wbs_cyc_i & wbs_stb_i & ~ack_q;
  // Full is judged on the registered count: a pop never frees a slot for the same cycle.
  assign push   = req & wbs_we_i & (count_q != FULL);
  assign pop    = (state_q == ST_WR) & wbm_ack_i;
  assign rd_go  = req & ~wbs_we_i & (count_q == '0) & (state_q == ST_IDLE);
  assign rd_nxt = rd_ptr_q + PW'(1);

  // FIFO storage, no reset needed: contents are only read below the count.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      adr_mem[wr_ptr_q] <= wbs_adr_i;
      sel_mem[wr_ptr_q] <= wbs_sel_i;
      dat_mem[wr_ptr_q] <= wbs_dat_i;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_nxt;
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Downstream FSM with registered bus outputs and the upstream ack/data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      abort_q <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
    end else begin
      ack_q <= push;
      case (state_q)
        ST_IDLE: begin
          // Queued writes always go before a waiting read.
          if (count_q != '0) begin
            state_q <= ST_WR;
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            adr_q   <= adr_mem[rd_ptr_q];
            sel_q   <= sel_mem[rd_ptr_q];
            wdat_q  <= dat_mem[rd_ptr_q];
          end else if (rd_go) begin
            state_q <= ST_RD;
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= wbs_adr_i;
            sel_q   <= wbs_sel_i;
            abort_q <= 1'b0;
          end
        end
        ST_WR: begin
          if (wbm_ack_i) begin
            // Keep strobing straight into the next entry when one is queued.
            if (count_q > CW'(1)) begin
              adr_q  <= adr_mem[rd_nxt];
              sel_q  <= sel_mem[rd_nxt];
              wdat_q <= dat_mem[rd_nxt];
            end else begin
              state_q <= ST_IDLE;
              cyc_q   <= 1'b0;
              we_q    <= 1'b0;
            end
          end
        end
        ST_RD: begin
          // Once the master walks away the read is finished silently.
          if (!wbs_cyc_i) abort_q <= 1'b1;
          if (wbm_ack_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            if (wbs_cyc_i && !abort_q) begin
              rdat_q <= wbm_dat_i;
              ack_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;

`ifdef WB_HR_WBUF_STATUS_EN
  assign wbuf_level_o = count_q;
  assign wbuf_busy_o  = (count_q != '0) | (state_q != ST_IDLE);
`endif

endmodule
